// File: rtl/project_1_pkg.sv
// Shared definitions for the result BCD display block: FSM state encoding,
// active-low 7-segment patterns and small combinational helpers.
package project_1_pkg;

  // Number of decimal digits produced from an 8-bit unsigned value.
  localparam int BCD_DIGITS = 3;

  // Width of the packed BCD display value.
  localparam int BCD_W = 4 * BCD_DIGITS;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // Segment patterns {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Decimal digit to segment pattern; non-decimal codes turn every segment off.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

  // Shift-add-3 correction of one BCD nibble ahead of the next shift.
  function automatic logic [3:0] add3(input logic [3:0] nibble);
    logic [3:0] corrected;
    if (nibble >= 4'd5) begin
      corrected = nibble + 4'd3;
    end else begin
      corrected = nibble;
    end
    return corrected;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double dabble) binary to BCD engine.
// A start pulse loads the operand; eight shifts later 'last' is high for the
// cycle in which the final shift happens, and 'result' then holds the digits
// until the next start.
module bin2bcd_seq
  import project_1_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       din,
  output logic             last,
  output logic [BCD_W-1:0] result
);

  // {hundreds, tens, ones, binary}; the binary part empties as digits fill in.
  logic [19:0] shift;
  logic [2:0]  iter;
  logic        running;
  logic [19:0] adjusted;

  // Correct every BCD nibble that would overflow when doubled.
  always_comb begin
    adjusted        = shift;
    adjusted[19:16] = add3(shift[19:16]);
    adjusted[15:12] = add3(shift[15:12]);
    adjusted[11:8]  = add3(shift[11:8]);
  end

  // Load on start, then perform one correct-and-shift step per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift   <= 20'd0;
      iter    <= 3'd0;
      running <= 1'b0;
    end else if (start) begin
      shift   <= {12'd0, din};
      iter    <= 3'd0;
      running <= 1'b1;
    end else if (running) begin
      shift <= {adjusted[18:0], 1'b0};
      iter  <= iter + 3'd1;
      if (iter == 3'd7) begin
        running <= 1'b0;
      end else begin
        running <= 1'b1;
      end
    end else begin
      shift   <= shift;
      iter    <= iter;
      running <= 1'b0;
    end
  end

  assign last   = running && (iter == 3'd7);
  assign result = shift[19:8];

endmodule

// File: rtl/result_bcd_display.sv
// Captures an 8-bit ALU result, converts it to three BCD digits with a
// sequential engine and drives a multiplexed 3-digit active-low 7-segment
// display with leading-zero blanking. A result arriving while a conversion is
// running is parked in a one-deep pending register (latest value wins).
module result_bcd_display
  import project_1_pkg::*;
#(
  parameter int REFRESH_DIV = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [7:0]       Din,
  input  logic             Load,
  output logic             Busy,
  output logic [BCD_W-1:0] Bcd,
  output logic [6:0]       Seg,
  output logic [2:0]       An
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  state_t           state;
  logic             pend;
  logic [7:0]       pend_val;
  logic             start;
  logic [7:0]       start_val;
  logic             conv_last;
  logic [BCD_W-1:0] conv_result;

  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       digit_idx;
  logic             refresh_wrap;
  logic [1:0]       digit_idx_nxt;
  logic [BCD_W-1:0] bcd_nxt;
  logic [6:0]       seg_nxt;

  // Decide when the engine (re)starts and with which operand. In LATCH a Load
  // in that very cycle is newer than anything pending, so it takes priority.
  always_comb begin
    start     = 1'b0;
    start_val = Din;
    case (state)
      ST_IDLE: begin
        start     = Load;
        start_val = Din;
      end
      ST_LATCH: begin
        start = Load | pend;
        if (Load) begin
          start_val = Din;
        end else begin
          start_val = pend_val;
        end
      end
      default: begin
        start     = 1'b0;
        start_val = Din;
      end
    endcase
  end

  bin2bcd_seq u_conv (
    .clk    (Clk),
    .rst    (Rst),
    .start  (start),
    .din    (start_val),
    .last   (conv_last),
    .result (conv_result)
  );

  // Control FSM with registered Busy, display value and pending capture.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= ST_IDLE;
      Busy     <= 1'b0;
      Bcd      <= {BCD_W{1'b0}};
      pend     <= 1'b0;
      pend_val <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Load) begin
            state <= ST_CONV;
            Busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end
        end
        ST_CONV: begin
          Busy <= 1'b1;
          if (Load) begin
            pend     <= 1'b1;
            pend_val <= Din;
          end else begin
            pend     <= pend;
            pend_val <= pend_val;
          end
          if (conv_last) begin
            state <= ST_LATCH;
          end else begin
            state <= ST_CONV;
          end
        end
        ST_LATCH: begin
          Bcd  <= conv_result;
          pend <= 1'b0;
          if (start) begin
            state <= ST_CONV;
            Busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
          pend  <= 1'b0;
        end
      endcase
    end
  end

  // Next display value and next digit position, so Seg/An can be registered
  // without lagging Bcd or the digit index by a cycle.
  always_comb begin
    refresh_wrap = (refresh_cnt == CNT_LAST);
    if (refresh_wrap) begin
      if (digit_idx == 2'd2) begin
        digit_idx_nxt = 2'd0;
      end else begin
        digit_idx_nxt = digit_idx + 2'd1;
      end
    end else begin
      digit_idx_nxt = digit_idx;
    end
    if (state == ST_LATCH) begin
      bcd_nxt = conv_result;
    end else begin
      bcd_nxt = Bcd;
    end
  end

  // Select the digit to show and apply leading-zero blanking.
  always_comb begin
    seg_nxt = SEG_BLANK;
    case (digit_idx_nxt)
      2'd0: begin
        seg_nxt = seg_encode(bcd_nxt[3:0]);
      end
      2'd1: begin
        if ((bcd_nxt[7:4] == 4'd0) && (bcd_nxt[11:8] == 4'd0)) begin
          seg_nxt = SEG_BLANK;
        end else begin
          seg_nxt = seg_encode(bcd_nxt[7:4]);
        end
      end
      2'd2: begin
        if (bcd_nxt[11:8] == 4'd0) begin
          seg_nxt = SEG_BLANK;
        end else begin
          seg_nxt = seg_encode(bcd_nxt[11:8]);
        end
      end
      default: begin
        seg_nxt = SEG_BLANK;
      end
    endcase
  end

  // Refresh timer, digit scan and registered display pins.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      refresh_cnt <= {CNT_W{1'b0}};
      digit_idx   <= 2'd0;
      An          <= 3'b110;
      Seg         <= SEG_0;
    end else begin
      if (refresh_wrap) begin
        refresh_cnt <= {CNT_W{1'b0}};
      end else begin
        refresh_cnt <= refresh_cnt + CNT_W'(1);
      end
      digit_idx <= digit_idx_nxt;
      An        <= ~(3'b001 << digit_idx_nxt);
      Seg       <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_result_bcd_display.sv
// Self-checking bench for result_bcd_display with a cycle-level reference
// model built from conversion latency, pending semantics and decimal digits.
module tb_result_bcd_display;

  localparam int DIV = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [7:0]  Din = 8'd0;
  logic        Load = 1'b0;
  logic        Busy;
  logic [11:0] Bcd;
  logic [6:0]  Seg;
  logic [2:0]  An;

  always #5 Clk = ~Clk;

  result_bcd_display #(.REFRESH_DIV(DIV)) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .Din  (Din),
    .Load (Load),
    .Busy (Busy),
    .Bcd  (Bcd),
    .Seg  (Seg),
    .An   (An)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int m_rem;     // cycles until the running conversion lands (0 = idle)
  int m_cur;     // value being converted
  int m_pend;
  int m_pval;
  int m_val;     // value currently shown
  int m_edges;   // clock edges since reset release

  logic [6:0] seg_tab [10];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int to_bcd(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic int exp_seg(input int v, input int idx);
    int d;
    if (idx == 0) d = v % 10;
    else if (idx == 1) d = (v / 10) % 10;
    else d = v / 100;
    if (idx == 2 && v < 100) return 7'h7f;
    if (idx == 1 && v < 10) return 7'h7f;
    return int'(seg_tab[d]);
  endfunction

  task automatic check_all(input string tag);
    int idx;
    idx = (m_edges / DIV) % 3;
    check({tag, ".busy"}, int'(Busy), (m_rem != 0) ? 1 : 0);
    check({tag, ".bcd"}, int'(Bcd), to_bcd(m_val));
    check({tag, ".an"}, int'(An), 7 - (1 << idx));
    check({tag, ".seg"}, int'(Seg), exp_seg(m_val, idx));
  endtask

  task automatic model_reset();
    m_rem = 0; m_cur = 0; m_pend = 0; m_pval = 0; m_val = 0; m_edges = 0;
  endtask

  task automatic step(input bit l, input int d, input string tag);
    Load = l;
    Din  = 8'(d);
    @(posedge Clk);
    if (m_rem == 0) begin
      if (l) begin m_cur = d; m_rem = 9; end
    end else begin
      if (l) begin m_pend = 1; m_pval = d; end
      m_rem--;
      if (m_rem == 0) begin
        m_val = m_cur;
        if (m_pend != 0) begin m_cur = m_pval; m_pend = 0; m_rem = 9; end
      end
    end
    m_edges++;
    #1;
    Load = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 0, tag);
  endtask

  // Assert reset mid low-phase and check outputs before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge Clk);
    #1 Rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 Rst = 1'b0;
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
    model_reset();

    // Reset state.
    do_reset("reset0");
    idle(3, "idle0");

    // Small product with blanked upper digits.
    step(1'b1, 8, "ld8");
    idle(14, "conv8");

    // Boundary values.
    step(1'b1, 255, "ld255");
    idle(14, "conv255");
    step(1'b1, 100, "ld100");
    idle(14, "conv100");
    step(1'b1, 0, "ld0");
    idle(14, "conv0");

    // Loads during conversion: latest pending wins.
    step(1'b1, 37, "ld37");
    idle(2, "p1");
    step(1'b1, 200, "ld200");
    idle(2, "p2");
    step(1'b1, 6, "ld6");
    idle(16, "p3");

    // Load in the LATCH cycle chains directly into the next conversion.
    step(1'b1, 50, "ld50");
    idle(8, "l1");
    step(1'b1, 77, "ld77");
    idle(14, "l2");

    // Reset mid-conversion discards everything, including pending.
    step(1'b1, 123, "ld123");
    idle(2, "r1");
    step(1'b1, 45, "ld45");
    do_reset("reset1");
    idle(16, "r2");

    // Refresh scan over a long idle period.
    step(1'b1, 189, "ld189");
    idle(30, "scan");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 5) == 0), int'($urandom_range(0, 255)), "rnd");
    end
    idle(20, "drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
